sha_compress_engine: RTL

//  Sequential SHA-256 compression engine: takes one 512-bit message block and a 256-bit chaining value,

---
 rtl/sha_pkg.sv | 68 ++++++
 rtl/sha_round_core.sv | 21 ++
 rtl/sha_compress_engine.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/sha_pkg.sv
// Shared SHA-256 definitions: round constants, initial hash value, FSM encoding
// and the bitwise helper functions used by the round core and the schedule.
package sha_pkg;

    typedef logic [255:0] sha_state_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ROUND = 2'd1,
        FINAL = 2'd2
    } eng_state_e;

    localparam logic [31:0] K [0:63] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
        32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
        32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
        32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
        32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
        32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
        32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
        32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
        32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    // Lane 0 (bits [31:0]) holds A, lane 7 holds H.
    localparam sha_state_t IV = {
        32'h5be0cd19, 32'h1f83d9ab, 32'h9b05688c, 32'h510e527f,
        32'ha54ff53a, 32'h3c6ef372, 32'hbb67ae85, 32'h6a09e667
    };

    function automatic logic [31:0] rotr(input logic [31:0] x, input int unsigned n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [31:0] Ch(input logic [31:0] x, input logic [31:0] y,
                                       input logic [31:0] z);
        return (x & y) ^ (~x & z);
    endfunction

    function automatic logic [31:0] Maj(input logic [31:0] x, input logic [31:0] y,
                                        input logic [31:0] z);
        return (x & y) ^ (x & z) ^ (y & z);
    endfunction

    function automatic logic [31:0] S0(input logic [31:0] x);
        return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
    endfunction

    function automatic logic [31:0] S1(input logic [31:0] x);
        return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
    endfunction

    function automatic logic [31:0] s0(input logic [31:0] x);
        return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
    endfunction

    function automatic logic [31:0] s1(input logic [31:0] x);
        return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
    endfunction

endpackage

// File: rtl/sha_round_core.sv
// One combinational SHA-256 round: (A..H, K[t], W[t]) -> next A..H.
module sha_round_core
    import sha_pkg::*;
(
    input  sha_state_t  state_in,
    input  logic [31:0] k_in,
    input  logic [31:0] w_in,
    output sha_state_t  state_out
);

    logic [31:0] a, b, c, d, e, f, g, h;
    logic [31:0] t1, t2;

    always_comb begin
        {h, g, f, e, d, c, b, a} = state_in;
        t1 = h + S1(e) + Ch(e, f, g) + k_in + w_in;
        t2 = S0(a) + Maj(a, b, c);
        state_out = {g, f, e, d + t1, c, b, a, t1 + t2};
    end

endmodule

// File: rtl/sha_compress_engine.sv
// Multi-cycle SHA-256 compression: ROUNDS_PER_CYCLE chained rounds per clock,
// sliding 16-word message schedule window, optional feed-forward, start/done/abort.
module sha_compress_engine
    import sha_pkg::*;
#(
    parameter int ROUNDS_PER_CYCLE = 1,
    parameter int FEED_FORWARD     = 1
) (
    input  logic         clk,
    input  logic         n_rst,
    input  logic         start,
    input  logic         abort,
    input  logic [511:0] block_in,
    input  logic [255:0] chain_in,
    output logic         ready,
    output logic         done,
    output logic [255:0] digest,
    output logic [255:0] dbg_state
);

    eng_state_e  state_q, state_d;
    logic [6:0]  cnt_q, cnt_d;
    logic [31:0] w_q [0:15];
    logic [31:0] w_d [0:15];
    logic [31:0] w_shift [0:15];
    logic [31:0] ext [0:15+ROUNDS_PER_CYCLE];
    sha_state_t  work_q, work_d;
    sha_state_t  chain_q, chain_d;
    sha_state_t  digest_q, digest_d;
    sha_state_t  rounds_out;
    wire [255:0] ff_sum;
    logic        done_q, done_d;

    // Window holds W[cnt..cnt+15]; extend it by RPC words, then slide.
    always_comb begin
        for (int i = 0; i < 16; i++) begin
            ext[i] = w_q[i];
        end
        for (int j = 0; j < ROUNDS_PER_CYCLE; j++) begin
            ext[16+j] = s1(ext[14+j]) + ext[9+j] + s0(ext[1+j]) + ext[j];
        end
        for (int i = 0; i < 16; i++) begin
            w_shift[i] = ext[i+ROUNDS_PER_CYCLE];
        end
    end

    genvar gi;
    for (gi = 0; gi < ROUNDS_PER_CYCLE; gi++) begin : g_round
        sha_state_t st_in;
        sha_state_t st_out;
        logic [5:0] t_idx;

        if (gi == 0) begin : g_first
            assign st_in = work_q;
        end else begin : g_next
            assign st_in = g_round[gi-1].st_out;
        end

        assign t_idx = cnt_q[5:0] + 6'(gi);

        sha_round_core u_core (
            .state_in  (st_in),
            .k_in      (K[t_idx]),
            .w_in      (w_q[gi]),
            .state_out (st_out)
        );
    end

    assign rounds_out = g_round[ROUNDS_PER_CYCLE-1].st_out;

    for (gi = 0; gi < 8; gi++) begin : g_ff
        if (FEED_FORWARD != 0) begin : g_add
            assign ff_sum[32*gi +: 32] = work_q[32*gi +: 32] + chain_q[32*gi +: 32];
        end else begin : g_raw
            assign ff_sum[32*gi +: 32] = work_q[32*gi +: 32];
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        work_d   = work_q;
        chain_d  = chain_q;
        digest_d = digest_q;
        done_d   = 1'b0;
        for (int i = 0; i < 16; i++) begin
            w_d[i] = w_q[i];
        end

        if (abort) begin
            state_d = IDLE;
            cnt_d   = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    // done_q marks the pulse cycle, during which a new start is refused.
                    if (start && !done_q) begin
                        for (int i = 0; i < 16; i++) begin
                            w_d[i] = block_in[511-32*i -: 32];
                        end
                        work_d  = chain_in;
                        chain_d = chain_in;
                        cnt_d   = '0;
                        state_d = ROUND;
                    end
                end
                ROUND: begin
                    work_d = rounds_out;
                    for (int i = 0; i < 16; i++) begin
                        w_d[i] = w_shift[i];
                    end
                    cnt_d = cnt_q + 7'(ROUNDS_PER_CYCLE);
                    if (cnt_q == 7'(64 - ROUNDS_PER_CYCLE)) begin
                        state_d = FINAL;
                    end
                end
                FINAL: begin
                    digest_d = ff_sum;
                    done_d   = 1'b1;
                    cnt_d    = '0;
                    state_d  = IDLE;
                end
                default: begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            work_q   <= '0;
            chain_q  <= '0;
            digest_q <= '0;
            done_q   <= 1'b0;
            for (int i = 0; i < 16; i++) begin
                w_q[i] <= '0;
            end
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            work_q   <= work_d;
            chain_q  <= chain_d;
            digest_q <= digest_d;
            done_q   <= done_d;
            for (int i = 0; i < 16; i++) begin
                w_q[i] <= w_d[i];
            end
        end
    end

    assign ready     = (state_q == IDLE) && !done_q;
    assign done      = done_q;
    assign digest    = digest_q;
    assign dbg_state = work_q;

endmodule
